flash_word_reader: RTL and testbench

Avalon-MM read master that walks the audio region of flash one 32-bit word at a time and hands words to the byte-select/playback stage. It sits directly upstream of the flash driver's byte multiplexer, replacing free-running reads with a one-word prefetch buffer. It also supports forward and reverse playback with wrap-around at the song boundaries. Each word is issued to the downstream stage on a single-cycle `step` request.

---
 rtl/flash_pkg.sv | 20 ++
 rtl/flash_addr_seq.sv | 47 ++++
 rtl/flash_word_reader.sv | 175 +++++++++++++++++
 tb/tb_flash_word_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared types and constants for the flash word reader and its address sequencer.
package flash_pkg;

    localparam int FLASH_ADDR_W = 23;

    localparam logic [FLASH_ADDR_W-1:0] FLASH_START_ADDR = 23'h000000;
    localparam logic [FLASH_ADDR_W-1:0] FLASH_END_ADDR   = 23'h07FFFF;

    localparam int FLASH_DATA_W      = 32;
    localparam int FLASH_UNDERRUN_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FLUSH,
        FULL
    } flash_rd_state_t;

endpackage

// File: rtl/flash_addr_seq.sv
// Word address register for the audio region: steps forward/backward with
// wrap at the region bounds, or reloads the song start on restart.
module flash_addr_seq
    import flash_pkg::*;
#(
    parameter int                ADDR_W     = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FLASH_START_ADDR),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(FLASH_END_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic              reverse,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Reload wins over advance so a restart never lands one word off the start.
    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = reverse ? END_ADDR : START_ADDR;
        end else if (advance) begin
            if (reverse) begin
                addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - ONE;
            end else begin
                addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= START_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/flash_word_reader.sv
// Avalon-MM read master with a one-word prefetch buffer feeding the playback stage.
// Define FLASH_READER_UNDERRUN_CNT_EN to build the saturating underrun counter.
module flash_word_reader
    import flash_pkg::*;
#(
    parameter int                ADDR_W     = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FLASH_START_ADDR),
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(FLASH_END_ADDR)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        reverse,
    input  logic                        restart,
    input  logic                        step,
    input  logic                        flash_mem_waitrequest,
    input  logic [FLASH_DATA_W-1:0]     flash_mem_readdata,
    input  logic                        flash_mem_readdatavalid,
    output logic                        flash_mem_read,
    output logic [ADDR_W-1:0]           flash_mem_address,
    output logic [FLASH_DATA_W-1:0]     flash_data,
    output logic                        flash_data_valid,
    output logic [FLASH_UNDERRUN_W-1:0] underrun_count
);

    flash_rd_state_t state_q, state_d;

    logic                    restart_pend_q, restart_pend_d;
    logic [FLASH_DATA_W-1:0] buf_q, buf_d;
    logic [FLASH_DATA_W-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    read_q, read_d;
    logic                    addr_load;
    logic                    addr_advance;

    flash_addr_seq #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_addr_seq (
        .clk     (clk),
        .reset   (reset),
        .load    (addr_load),
        .advance (addr_advance),
        .reverse (reverse),
        .addr    (flash_mem_address)
    );

    // A restart seen while a read is stalled is remembered and applied once the
    // slave accepts, since the address must stay put until then.
    always_comb begin
        state_d        = state_q;
        restart_pend_d = restart_pend_q;
        buf_d          = buf_q;
        data_d         = data_q;
        valid_d        = 1'b0;
        addr_load      = 1'b0;
        addr_advance   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (restart) begin
                    addr_load = 1'b1;
                end
                if (enable) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                if (!flash_mem_waitrequest) begin
                    if (restart || restart_pend_q) begin
                        addr_load      = 1'b1;
                        restart_pend_d = 1'b0;
                        state_d        = FLUSH;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (restart) begin
                    restart_pend_d = 1'b1;
                end
            end

            WAIT: begin
                if (restart) begin
                    addr_load = 1'b1;
                    if (flash_mem_readdatavalid) begin
                        state_d = enable ? REQ : IDLE;
                    end else begin
                        state_d = FLUSH;
                    end
                end else if (flash_mem_readdatavalid) begin
                    buf_d   = flash_mem_readdata;
                    state_d = FULL;
                end
            end

            FLUSH: begin
                if (restart) begin
                    addr_load = 1'b1;
                end
                if (flash_mem_readdatavalid) begin
                    state_d = enable ? REQ : IDLE;
                end
            end

            FULL: begin
                if (restart) begin
                    addr_load = 1'b1;
                    state_d   = enable ? REQ : IDLE;
                end else if (step && enable) begin
                    data_d       = buf_q;
                    valid_d      = 1'b1;
                    addr_advance = 1'b1;
                    state_d      = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        read_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            restart_pend_q <= 1'b0;
            buf_q          <= '0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            read_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            restart_pend_q <= restart_pend_d;
            buf_q          <= buf_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            read_q         <= read_d;
        end
    end

    assign flash_mem_read   = read_q;
    assign flash_data       = data_q;
    assign flash_data_valid = valid_q;

`ifdef FLASH_READER_UNDERRUN_CNT_EN
    logic                        underrun;
    logic [FLASH_UNDERRUN_W-1:0] ucnt_q, ucnt_d;

    assign underrun = step && enable && (state_q != FULL);

    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun && (ucnt_q != {FLASH_UNDERRUN_W{1'b1}})) begin
            ucnt_d = ucnt_q + FLASH_UNDERRUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;
`else
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_flash_word_reader.sv
// Directed testbench for flash_word_reader with a small hand-driven flash slave.
module tb_flash_word_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        reverse;
    logic        restart;
    logic        step;
    logic        flash_mem_waitrequest;
    logic [31:0] flash_mem_readdata;
    logic        flash_mem_readdatavalid;
    logic        flash_mem_read;
    logic [22:0] flash_mem_address;
    logic [31:0] flash_data;
    logic        flash_data_valid;
    logic [7:0]  underrun_count;

    int totalChecks = 0;
    int badChecks   = 0;

`ifdef FLASH_READER_UNDERRUN_CNT_EN
    localparam int UCNT_AFTER5   = 5;
    localparam int UCNT_SATURATE = 255;
`else
    localparam int UCNT_AFTER5   = 0;
    localparam int UCNT_SATURATE = 0;
`endif

    flash_word_reader #(
        .ADDR_W     (23),
        .START_ADDR (23'h000000),
        .END_ADDR   (23'h000007)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .reverse                 (reverse),
        .restart                 (restart),
        .step                    (step),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_data              (flash_data),
        .flash_data_valid        (flash_data_valid),
        .underrun_count          (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic rev, input logic rst, input logic stp);
        enable  = en;
        reverse = rev;
        restart = rst;
        step    = stp;
    endtask

    // Waits for a read, holds waitrequest for waitCyc cycles, then accepts it.
    task automatic acceptRead(input logic [22:0] expAddr, input int waitCyc);
        int guard = 0;
        while (flash_mem_read !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("readRise", 32'(flash_mem_read), 32'd1);
        checkOutput("readAddr", 32'(flash_mem_address), 32'(expAddr));
        flash_mem_waitrequest = 1'b1;
        for (int i = 0; i < waitCyc; i++) begin
            tick();
            checkOutput("holdRead", 32'(flash_mem_read), 32'd1);
            checkOutput("holdAddr", 32'(flash_mem_address), 32'(expAddr));
        end
        flash_mem_waitrequest = 1'b0;
        tick();
        flash_mem_waitrequest = 1'b1;
        checkOutput("readDrop", 32'(flash_mem_read), 32'd0);
    endtask

    task automatic returnData(input int lat, input logic [31:0] d);
        repeat (lat - 1) tick();
        flash_mem_readdata      = d;
        flash_mem_readdatavalid = 1'b1;
        tick();
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0;
    endtask

    task automatic doStep(input logic [31:0] expData, input logic [22:0] expAddr);
        step = 1'b1;
        tick();
        step = 1'b0;
        checkOutput("stepData", flash_data, expData);
        checkOutput("stepValid", 32'(flash_data_valid), 32'd1);
        checkOutput("stepAddr", 32'(flash_mem_address), 32'(expAddr));
        checkOutput("stepRead", 32'(flash_mem_read), 32'd1);
        tick();
        checkOutput("validPulse", 32'(flash_data_valid), 32'd0);
    endtask

    initial begin
        logic [22:0] nextAddr;
        logic        validSeen;

        reset                   = 1'b0;
        flash_mem_waitrequest   = 1'b1;
        flash_mem_readdata      = 32'h0;
        flash_mem_readdatavalid = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        checkOutput("rstRead", 32'(flash_mem_read), 32'd0);
        checkOutput("rstAddr", 32'(flash_mem_address), 32'd0);
        checkOutput("rstData", flash_data, 32'h0);
        checkOutput("rstValid", 32'(flash_data_valid), 32'd0);
        checkOutput("rstUcnt", 32'(underrun_count), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("idleRead", 32'(flash_mem_read), 32'd0);

        $display("[TB] first word fetch");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        acceptRead(23'd0, 2);
        returnData(3, 32'hDEADBEEF);
        checkOutput("fullNoValid", 32'(flash_data_valid), 32'd0);
        checkOutput("fullDataHeld", flash_data, 32'h0);
        doStep(32'hDEADBEEF, 23'd1);

        $display("[TB] forward walk with long waitrequest and wrap");
        for (int a = 1; a <= 7; a++) begin
            nextAddr = (a == 7) ? 23'd0 : 23'(a + 1);
            acceptRead(23'(a), (a == 1) ? 10 : 0);
            returnData(2, 32'hA0000000 | 32'(a));
            doStep(32'hA0000000 | 32'(a), nextAddr);
        end

        $display("[TB] reverse wrap from start");
        acceptRead(23'd0, 0);
        returnData(1, 32'hB0000000);
        reverse = 1'b1;
        doStep(32'hB0000000, 23'd7);
        acceptRead(23'd7, 1);
        returnData(2, 32'hB0000007);
        doStep(32'hB0000007, 23'd6);

        $display("[TB] restart during WAIT");
        acceptRead(23'd6, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        checkOutput("rstrtRead", 32'(flash_mem_read), 32'd0);
        checkOutput("rstrtAddr", 32'(flash_mem_address), 32'd7);
        tick();
        flash_mem_readdata      = 32'h11111111;
        flash_mem_readdatavalid = 1'b1;
        tick();
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0;
        checkOutput("flushValid", 32'(flash_data_valid), 32'd0);
        checkOutput("flushData", flash_data, 32'hB0000007);
        checkOutput("flushReq", 32'(flash_mem_read), 32'd1);
        checkOutput("flushAddr", 32'(flash_mem_address), 32'd7);
        tick();
        checkOutput("flushValid2", 32'(flash_data_valid), 32'd0);

        $display("[TB] underrun burst in WAIT");
        acceptRead(23'd7, 0);
        validSeen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            if (flash_data_valid === 1'b1) validSeen = 1'b1;
            tick();
            if (i == 4) checkOutput("ucnt5", 32'(underrun_count), 32'(UCNT_AFTER5));
        end
        checkOutput("urunValid", 32'(validSeen), 32'd0);
        checkOutput("urunData", flash_data, 32'hB0000007);
        checkOutput("ucntSat", 32'(underrun_count), 32'(UCNT_SATURATE));
        returnData(1, 32'h22222222);
        doStep(32'h22222222, 23'd6);

        $display("[TB] enable dropped during WAIT");
        acceptRead(23'd6, 0);
        enable = 1'b0;
        tick();
        returnData(2, 32'h33333333);
        validSeen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (flash_mem_read === 1'b1) validSeen = 1'b1;
        end
        checkOutput("disNoRead", 32'(validSeen), 32'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        checkOutput("disStepValid", 32'(flash_data_valid), 32'd0);
        checkOutput("disStepData", flash_data, 32'h22222222);
        checkOutput("disStepRead", 32'(flash_mem_read), 32'd0);
        checkOutput("disStepAddr", 32'(flash_mem_address), 32'd6);
        checkOutput("disUcnt", 32'(underrun_count), 32'(UCNT_SATURATE));
        enable = 1'b1;
        tick();
        checkOutput("reenNoRead", 32'(flash_mem_read), 32'd0);
        doStep(32'h33333333, 23'd5);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got=running exp=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
